// File: rtl/ws2812_rx.sv
// ws2812_rx: single-wire WS2812 stream decoder.
// Synchronises din, measures each high pulse and low gap, decodes bits
// MSB-first in G,R,B wire order, and reports each pixel as {R,G,B} with its
// 0-based index inside the frame. A low gap of t_latch cycles ends a frame.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   din        serial WS2812 data line (asynchronous to clk)
//   rgb_data   last decoded pixel {R,G,B}, held between valid strobes
//   led_num    index of the pixel in rgb_data, held between valid strobes
//   valid      one-cycle strobe: rgb_data/led_num updated
//   frame_done one-cycle strobe: latch gap seen after at least one pulse
//   overflow   one-cycle strobe: pixel index >= leds received and dropped
//   err        one-cycle strobe: glitch, stuck-high line, or partial pixel at latch
module ws2812_rx #(
  parameter int leds     = 8,
  parameter int t_min    = 2,
  parameter int t_thresh = 6,
  parameter int t_latch  = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        valid,
  output logic        frame_done,
  output logic        overflow,
  output logic        err
);

  localparam int CNT_W = $clog2(t_latch + 1);
  localparam logic [CNT_W-1:0] LATCH = CNT_W'(t_latch);
  localparam logic [CNT_W-1:0] TMIN  = CNT_W'(t_min);
  localparam logic [CNT_W-1:0] TTHR  = CNT_W'(t_thresh);
  localparam logic [7:0]       LEDS  = 8'(leds);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  // Counters stop at t_latch so a long idle line never wraps into a false pulse.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LATCH) ? v : v + CNT_W'(1);
  endfunction

  // Wire order is G,R,B; the outside world wants R,G,B.
  function automatic logic [23:0] grb_to_rgb(input logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction

  logic             din_p0, din_s, din_prev;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic             rise, fall, bit_v;
  logic [22:0]      shift;
  logic [23:0]      word;
  logic [4:0]       bit_cnt;
  logic [7:0]       pix_cnt;
  state_t           state;

  // ---- stage p0/p1: two-flop synchroniser plus previous value for edges ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_p0   <= 1'b0;
      din_s    <= 1'b0;
      din_prev <= 1'b0;
    end else begin
      din_p0   <= din;
      din_s    <= din_p0;
      din_prev <= din_s;
    end
  end

  assign rise = din_s & ~din_prev;
  assign fall = ~din_s & din_prev;

  // ---- stage p2: run-length counters on the synchronised line ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      high_cnt <= din_s ? sat_inc(high_cnt) : '0;
      low_cnt  <= din_s ? '0 : sat_inc(low_cnt);
    end
  end

  // On a fall, high_cnt still holds the full width of the pulse that just ended.
  assign bit_v = (high_cnt >= TTHR);
  assign word  = {shift, bit_v};

  // ---- stage p3: decode FSM with registered strobes and pixel outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      shift      <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      rgb_data   <= '0;
      led_num    <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      err        <= 1'b0;
      case (state)
        SYNC: begin
          // Wait for a clean latch gap before trusting any pulse.
          if (low_cnt == LATCH) state <= rise ? HIGH : IDLE;
        end
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (high_cnt == LATCH) begin
            err     <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            state   <= SYNC;
          end else if (fall) begin
            state <= LOW;
            if (high_cnt < TMIN) begin
              err <= 1'b1;
            end else if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              shift   <= word[22:0];
              if (pix_cnt < LEDS) begin
                valid    <= 1'b1;
                rgb_data <= grb_to_rgb(word);
                led_num  <= pix_cnt;
                pix_cnt  <= pix_cnt + 8'd1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shift   <= word[22:0];
            end
          end
        end
        LOW: begin
          if (low_cnt == LATCH) begin
            frame_done <= 1'b1;
            err        <= (bit_cnt != 5'd0);
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            shift      <= '0;
            state      <= rise ? HIGH : IDLE;
          end else if (rise) begin
            state <= HIGH;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: pulse-level reference model plus per-cycle compare.
module tb_ws2812_rx;

  localparam int LEDS     = 2;
  localparam int T_MIN    = 2;
  localparam int T_THRESH = 6;
  localparam int T_LATCH  = 600;
  localparam int LAT      = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid, frame_done, overflow, err;

  ws2812_rx #(.leds(LEDS), .t_min(T_MIN), .t_thresh(T_THRESH), .t_latch(T_LATCH)) dut (
    .clk(clk), .reset(reset), .din(din), .rgb_data(rgb_data), .led_num(led_num),
    .valid(valid), .frame_done(frame_done), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state: pulse-level view of the decoder.
  bit          m_sync;
  int          m_nbits;
  logic [23:0] m_word;
  int          m_pix;
  bit          exp_valid[int];
  logic [23:0] exp_rgb[int];
  logic [7:0]  exp_led[int];
  bit          exp_fd[int];
  bit          exp_ovf[int];
  bit          exp_err[int];
  logic [23:0] cur_rgb;
  logic [7:0]  cur_led;

  // Observed strobe statistics.
  int n_valid = 0, n_fd = 0, n_err = 0, n_ovf = 0;
  int fd_cyc = -1, err_cyc = -1, last_tf = 0;
  int v0, f0, e0, o0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_sync  = 1'b1;
    m_nbits = 0;
    m_word  = '0;
    m_pix   = 0;
    cur_rgb = '0;
    cur_led = '0;
    exp_valid.delete();
    exp_rgb.delete();
    exp_led.delete();
    exp_fd.delete();
    exp_ovf.delete();
    exp_err.delete();
  endtask

  // One pulse: h cycles high starting now (tr), then l cycles low from tf.
  task automatic model_pulse(input int h, input int l, input int tr);
    int tf;
    tf = tr + h;
    if (m_sync) begin
      if (l >= T_LATCH) m_sync = 1'b0;
    end else if (h >= T_LATCH) begin
      exp_err[tr + T_LATCH + LAT] = 1'b1;
      m_nbits = 0;
      m_word  = '0;
      m_pix   = 0;
      m_sync  = (l < T_LATCH);
    end else begin
      if (h < T_MIN) begin
        exp_err[tf + LAT] = 1'b1;
      end else begin
        m_word = {m_word[22:0], (h >= T_THRESH)};
        m_nbits++;
        if (m_nbits == 24) begin
          m_nbits = 0;
          if (m_pix < LEDS) begin
            exp_valid[tf + LAT] = 1'b1;
            exp_rgb[tf + LAT]   = {m_word[15:8], m_word[23:16], m_word[7:0]};
            exp_led[tf + LAT]   = 8'(m_pix);
            m_pix++;
          end else begin
            exp_ovf[tf + LAT] = 1'b1;
          end
        end
      end
      if (l >= T_LATCH) begin
        exp_fd[tf + T_LATCH + LAT] = 1'b1;
        if (m_nbits != 0) exp_err[tf + T_LATCH + LAT] = 1'b1;
        m_nbits = 0;
        m_pix   = 0;
      end
    end
  endtask

  task automatic compare_cycle();
    bit ev, ef, eo, ee;
    if (!reset) begin
      check("rst_valid", 32'(valid), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_err", 32'(err), 0);
      check("rst_rgb", 32'(rgb_data), 0);
      check("rst_led", 32'(led_num), 0);
    end else begin
      ev = (exp_valid.exists(cyc) != 0);
      ef = (exp_fd.exists(cyc) != 0);
      eo = (exp_ovf.exists(cyc) != 0);
      ee = (exp_err.exists(cyc) != 0);
      if (ev) begin
        cur_rgb = exp_rgb[cyc];
        cur_led = exp_led[cyc];
      end
      check("valid", 32'(valid), 32'(ev));
      check("frame_done", 32'(frame_done), 32'(ef));
      check("overflow", 32'(overflow), 32'(eo));
      check("err", 32'(err), 32'(ee));
      check("rgb_data", 32'(rgb_data), 32'(cur_rgb));
      check("led_num", 32'(led_num), 32'(cur_led));
      if (valid) n_valid++;
      if (overflow) n_ovf++;
      if (frame_done) begin n_fd++; fd_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    model_pulse(h, l, cyc);
    din = 1'b1;
    repeat (h) tick();
    last_tf = cyc;
    din = 1'b0;
    repeat (l) tick();
  endtask

  task automatic idle(input int l);
    if (m_sync && l >= T_LATCH) m_sync = 1'b0;
    din = 1'b0;
    repeat (l) tick();
  endtask

  // Send the top n bits of w (wire order), 1 = 9H/5L, 0 = 4H/10L; the last
  // bit's low is last_low; a 1-cycle glitch follows bit number glitch_after.
  task automatic send_bits(input logic [23:0] w, input int n, input int last_low,
                           input int glitch_after);
    for (int k = 0; k < n; k++) begin
      logic b;
      int   h, l;
      b = w[23-k];
      h = b ? 9 : 4;
      l = (k == n - 1) ? last_low : (b ? 5 : 10);
      pulse(h, l);
      if (k + 1 == glitch_after) pulse(1, 5);
    end
  endtask

  task automatic snap();
    v0 = n_valid; f0 = n_fd; e0 = n_err; o0 = n_ovf;
  endtask

  initial begin
    reset = 1'b0;
    din   = 1'b0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) tick();
    check("init_rgb", 32'(rgb_data), 0);
    check("init_led", 32'(led_num), 0);
    check("init_valid", 32'(valid), 0);
    check("init_fd", 32'(frame_done), 0);
    reset = 1'b1;
    idle(620);

    // Basic pixel: wire BB,AA,CC -> {R,G,B} = AABBCC.
    snap();
    send_bits(24'hBBAACC, 24, 620, 0);
    check("t1_valid_cnt", n_valid - v0, 1);
    check("t1_rgb", 32'(rgb_data), 32'h00AABBCC);
    check("t1_led", 32'(led_num), 0);
    check("t1_fd_cnt", n_fd - f0, 1);
    check("t1_fd_latency", fd_cyc, last_tf + 603);
    check("t1_err_cnt", n_err - e0, 0);

    // Overflow with leds=2.
    snap();
    send_bits(24'hFF0000, 24, 10, 0);
    send_bits(24'h341256, 24, 10, 0);
    send_bits(24'hFFFFFF, 24, 620, 0);
    check("t2_valid_cnt", n_valid - v0, 2);
    check("t2_ovf_cnt", n_ovf - o0, 1);
    check("t2_led", 32'(led_num), 1);
    check("t2_rgb", 32'(rgb_data), 32'h00123456);

    // Glitch mid-pixel.
    snap();
    send_bits(24'h1E0F2D, 24, 620, 12);
    check("t3_err_cnt", n_err - e0, 1);
    check("t3_valid_cnt", n_valid - v0, 1);
    check("t3_rgb", 32'(rgb_data), 32'h000F1E2D);
    check("t3_led", 32'(led_num), 0);

    // Partial pixel at latch.
    snap();
    send_bits(24'hA5A5A5, 10, 620, 0);
    check("t4_fd_cnt", n_fd - f0, 1);
    check("t4_err_cnt", n_err - e0, 1);
    check("t4_fd_err_same", fd_cyc, err_cyc);
    check("t4_valid_cnt", n_valid - v0, 0);
    send_bits(24'h020103, 24, 620, 0);
    check("t4_rgb", 32'(rgb_data), 32'h00010203);
    check("t4_led", 32'(led_num), 0);

    // Stuck high mid-frame, then rises ignored until a full gap.
    snap();
    send_bits(24'h5A5A5A, 10, 10, 0);
    pulse(650, 10);
    pulse(9, 5);
    pulse(4, 10);
    pulse(9, 620);
    check("t5_err_cnt", n_err - e0, 1);
    check("t5_fd_cnt", n_fd - f0, 0);
    check("t5_valid_cnt", n_valid - v0, 0);
    send_bits(24'h11AA55, 24, 620, 0);
    check("t5_rgb", 32'(rgb_data), 32'h00AA1155);

    // Async reset mid-pixel.
    send_bits(24'h123456, 12, 10, 0);
    din = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    din   = 1'b0;
    #1;
    check("t6_rgb_async", 32'(rgb_data), 0);
    check("t6_led_async", 32'(led_num), 0);
    check("t6_valid_async", 32'(valid), 0);
    check("t6_err_async", 32'(err), 0);
    model_reset();
    tick();
    reset = 1'b1;
    snap();
    send_bits(24'hFFFFFF, 24, 620, 0);
    check("t6_ignored_valid", n_valid - v0, 0);
    check("t6_ignored_fd", n_fd - f0, 0);
    send_bits(24'h445566, 24, 620, 0);
    check("t6_valid_cnt", n_valid - v0, 1);
    check("t6_rgb", 32'(rgb_data), 32'h00554466);

    // Width boundaries: t_min, t_thresh-1, t_thresh, t_latch-1, 599 and 1-cycle lows.
    snap();
    pulse(2, 599);
    pulse(5, 1);
    pulse(6, 5);
    pulse(599, 5);
    send_bits(24'hC5A5A0, 20, 620, 0);
    check("t7_valid_cnt", n_valid - v0, 1);
    check("t7_err_cnt", n_err - e0, 0);
    check("t7_fd_cnt", n_fd - f0, 1);
    check("t7_rgb", 32'(rgb_data), 32'h005A3C5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
